// File: rtl/keccak_pkg.sv
// Shared constants, types and index helpers for the Keccak theta stage.
package keccak_pkg;

    localparam int NUM_PAGE   = 64;                         // lane depth (z)
    localparam int NUM_ROW    = 5;                          // rows (j)
    localparam int NUM_COLUMN = 5;                          // columns (i)
    localparam int LEN_PAGE   = NUM_ROW * NUM_COLUMN;       // 25 bits per z slice
    localparam int NUM_CELLS  = LEN_PAGE * NUM_PAGE;        // 1600
    localparam int IDX_W      = 11;                         // enough for 0..1599
    localparam int ROW_W      = 3;                          // row counter 0..4

    // FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PARITY = 2'd1,
        ST_APPLY  = 2'd2,
        ST_OUT    = 2'd3
    } theta_state_e;

    // One 5x64 plane: [i][z]. Used for both a row slice and the parity C.
    typedef logic [NUM_COLUMN-1:0][NUM_PAGE-1:0] plane_t;

    // Flat bit position of lane bit (i,j,z) in the 1600-bit state.
    function automatic logic [IDX_W-1:0] bit_idx(input int i, input int j, input int z);
        return IDX_W'(z * LEN_PAGE + (LEN_PAGE - 1) - (NUM_COLUMN * j + i));
    endfunction

endpackage

// File: rtl/keccak_theta_stage_if.sv
// Input/output bus of the theta stage.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The source holds valid and data stable until that edge;
// ready may be asserted independently of valid.
interface keccak_theta_stage_if;
    import keccak_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_CELLS-1:0] page_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [NUM_CELLS-1:0] page_out;
    logic                 busy;

    // Upstream/downstream environment around the stage
    modport master (
        output in_valid, page_in, out_ready,
        input  in_ready, out_valid, page_out, busy
    );

    // The theta stage itself
    modport slave (
        input  in_valid, page_in, out_ready,
        output in_ready, out_valid, page_out, busy
    );

endinterface

// File: rtl/keccak_theta_row.sv
// Combinational theta update of one row: each lane bit is XORed with the
// parity of the left column and the rotated parity of the right column.
module keccak_theta_row
    import keccak_pkg::*;
(
    input  plane_t row_in,
    input  plane_t c_in,
    output plane_t row_out
);

    // A[i][z] ^= C[i-1][z] ^ C[i+1][z-1], indices wrapping mod 5 / mod 64
    always_comb begin
        row_out = '0;
        for (int i = 0; i < NUM_COLUMN; i++) begin
            for (int z = 0; z < NUM_PAGE; z++) begin
                row_out[i][z] = row_in[i][z]
                              ^ c_in[(i + NUM_COLUMN - 1) % NUM_COLUMN][z]
                              ^ c_in[(i + 1) % NUM_COLUMN][(z + NUM_PAGE - 1) % NUM_PAGE];
            end
        end
    end

endmodule

// File: rtl/keccak_theta_stage.sv
// Iterative Keccak-f[1600] theta step: five cycles of row-serial column
// parity accumulation, five cycles of row-serial theta XOR, then the result
// is held on page_out until the downstream stage takes it.
module keccak_theta_stage
    import keccak_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    keccak_theta_stage_if.slave  bus,
    output theta_state_e         dbg_state
);

    theta_state_e          fsm_q, fsm_d;
    logic [NUM_CELLS-1:0]  state_q, state_d;
    plane_t                c_q, c_d;
    logic [ROW_W-1:0]      row_q, row_d;
    plane_t                row_slice;
    plane_t                row_theta;
    logic                  last_row;

    assign last_row = (row_q == ROW_W'(NUM_ROW - 1));

    // Extract row j=row_q of the state as a [i][z] plane
    always_comb begin
        row_slice = '0;
        for (int j = 0; j < NUM_ROW; j++) begin
            if (row_q == ROW_W'(j)) begin
                for (int i = 0; i < NUM_COLUMN; i++) begin
                    for (int z = 0; z < NUM_PAGE; z++) begin
                        row_slice[i][z] = state_q[bit_idx(i, j, z)];
                    end
                end
            end
        end
    end

    keccak_theta_row u_row (
        .row_in  (row_slice),
        .c_in    (c_q),
        .row_out (row_theta)
    );

    // Next-state logic: FSM, row counter, parity accumulation, row write-back
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        c_d     = c_q;
        row_d   = row_q;
        case (fsm_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = bus.page_in;
                    c_d     = '0;
                    row_d   = '0;
                    fsm_d   = ST_PARITY;
                end
            end
            ST_PARITY: begin
                c_d = c_q ^ row_slice;
                if (last_row) begin
                    row_d = '0;
                    fsm_d = ST_APPLY;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            ST_APPLY: begin
                // C stays frozen; only the current row is rewritten
                for (int j = 0; j < NUM_ROW; j++) begin
                    if (row_q == ROW_W'(j)) begin
                        for (int i = 0; i < NUM_COLUMN; i++) begin
                            for (int z = 0; z < NUM_PAGE; z++) begin
                                state_d[bit_idx(i, j, z)] = row_theta[i][z];
                            end
                        end
                    end
                end
                if (last_row) begin
                    row_d = '0;
                    fsm_d = ST_OUT;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            c_q     <= '0;
            row_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            c_q     <= c_d;
            row_q   <= row_d;
        end
    end

    // Status decoded from the FSM register only; page_out is the raw state
    assign bus.in_ready  = (fsm_q == ST_IDLE);
    assign bus.out_valid = (fsm_q == ST_OUT);
    assign bus.busy      = (fsm_q == ST_PARITY) || (fsm_q == ST_APPLY);
    assign bus.page_out  = state_q;
    assign dbg_state     = fsm_q;

endmodule

// File: tb/tb_keccak_theta_stage.sv
// Bench for keccak_theta_stage: directed vectors with hand-derived theta
// results, a scoreboard queue, and a monitor checking data and latency.
module tb_keccak_theta_stage;
    import keccak_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keccak_theta_stage_if bus ();
    theta_state_e dbg_state;

    keccak_theta_stage dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [NUM_CELLS-1:0] exp_q[$];
    int                   acc_q[$];

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, expv);
        end
    endtask

    task automatic chkv(input string name, input logic [NUM_CELLS-1:0] act,
                        input logic [NUM_CELLS-1:0] expv);
        int first;
        checks++;
        if (act !== expv) begin
            failures++;
            first = -1;
            for (int k = 0; k < NUM_CELLS; k++)
                if (first < 0 && act[k] !== expv[k]) first = k;
            $display("FAIL %s got_ones=%0d exp_ones=%0d first_diff_bit=%0d",
                     name, $countones(act), $countones(expv), first);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout", name);
    endtask

    function automatic logic [NUM_CELLS-1:0] vec_of(input int b[$]);
        logic [NUM_CELLS-1:0] v;
        v = '0;
        foreach (b[k]) v[b[k]] = 1'b1;
        return v;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (!rst && bus.out_valid && !prev_ov) begin
            if (acc_q.size() == 0) fail_now("latency_no_accept");
            else chk("latency", 32'(cyc), 32'(acc_q.pop_front() + 10));
        end
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) fail_now("unexpected_output");
            else chkv("page_out", bus.page_out, exp_q.pop_front());
        end
        prev_ov <= bus.out_valid && !rst;
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [NUM_CELLS-1:0] v, input logic [NUM_CELLS-1:0] e);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.in_ready) begin
            fail_now("send_wait_ready");
            return;
        end
        bus.page_in  = v;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.page_in  = '1;
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        chk("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (exp_q.size() != 0 || !bus.in_ready) fail_now("wait_idle");
    endtask

    // ---------------- stimulus ----------------
    int q[$];
    logic [NUM_CELLS-1:0] v24, e24, v1599, e1599, veven, v132, e132;

    initial begin
        q = '{24};                                          v24   = vec_of(q);
        q = '{24, 23, 18, 13, 8, 3, 45, 40, 35, 30, 25};    e24   = vec_of(q);
        q = '{1599};                                        v1599 = vec_of(q);
        q = '{1599, 20, 15, 10, 5, 0, 1598, 1593, 1588, 1583, 1578};
        e1599 = vec_of(q);
        q = '{24, 19};                                      veven = vec_of(q);
        q = '{132};                                         v132  = vec_of(q);
        q = '{132, 146, 141, 136, 131, 126, 173, 168, 163, 158, 153};
        e132  = vec_of(q);

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.page_in   = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chkv("rst_page_out", bus.page_out, '0);

        send('0, '0);          wait_idle();
        send(v24, e24);        wait_idle();
        send(v1599, e1599);    wait_idle();
        send(veven, veven);    wait_idle();
        send(v132, e132);      wait_idle();

        // Backpressure: hold the result while upstream keeps offering data
        bus.out_ready = 1'b0;
        send(v24, e24);
        begin
            int n = 0;
            while (!bus.out_valid && n < 50) begin
                @(posedge clk); #1; n++;
            end
            if (!bus.out_valid) fail_now("bp_wait_out_valid");
        end
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.page_in  = v1599;
            @(posedge clk); #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chkv("bp_page_stable", bus.page_out, e24);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", 32'(dbg_state), 32'(ST_IDLE));
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_second_accept", 32'(bus.busy), 32'd0);

        // Reset in APPLY row 2 discards the in-flight state
        send(v24, e24);
        repeat (7) @(posedge clk);
        #1;
        chk("mid_apply_state", 32'(dbg_state), 32'(ST_APPLY));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        chk("midrst_idle", 32'(dbg_state), 32'(ST_IDLE));
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chkv("midrst_page_out", bus.page_out, '0);

        send('0, '0);          wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

endmodule
